// File: rtl/regfile_multiport_if.sv
// Register-file access bundle: decode-side reads and busy marks,
// writeback-side writes, and the init-complete indication.
interface regfile_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wt_en;
    logic [ADDR_W-1:0]        wt_addr;
    logic [DATA_W-1:0]        wt_data;
    logic                     busy_set;
    logic [ADDR_W-1:0]        busy_addr;
    logic                     init_done;

    modport master (
        output rd_en, rd_addr, wt_en, wt_addr, wt_data,
        output busy_set, busy_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  rd_en, rd_addr, wt_en, wt_addr, wt_data,
        input  busy_set, busy_addr,
        output rd_data, rd_busy, init_done
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-port register file: N registered read ports, one write port,
// zero-init sweep after reset, optional r0, bypass and busy scoreboard.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic {INIT, RUN} state_e;

    localparam addr_t LAST = addr_t'(DEPTH - 1);
    localparam addr_t ONE  = addr_t'(1);

    state_e state_q, state_d;
    addr_t  cnt_q, cnt_d;

    logic [DEPTH-1:0] busy_q, busy_d;

    data_t mem_q [DEPTH];
    logic  mem_we;
    addr_t mem_addr;
    data_t mem_wdata;

    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    logic run;
    logic wt_ok;
    logic bs_ok;

    function automatic logic is_zero(input addr_t a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign run = (state_q == RUN);
    assign wt_ok = run && bus.wt_en && !is_zero(bus.wt_addr);
    assign bs_ok = run && bus.busy_set && !is_zero(bus.busy_addr);

    // Sweep sequencer: INIT walks every address once, then RUN forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Storage write port is shared between the zero sweep and writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (wt_ok) begin
            mem_we    = 1'b1;
            mem_addr  = bus.wt_addr;
            mem_wdata = bus.wt_data;
        end
    end

    // Scoreboard update: a completing write clears, a new producer sets.
    always_comb begin
        busy_d = busy_q;
        if (wt_ok) begin
            busy_d[bus.wt_addr] = 1'b0;
        end
        if (bs_ok) begin
            busy_d[bus.busy_addr] = 1'b1;
        end
    end

    // Next read-port values, with optional forwarding of the write port.
    always_comb begin
        addr_t ra;
        ra        = '0;
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        if (!run) begin
            rd_data_d = '0;
            rd_busy_d = '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (bus.rd_en[k]) begin
                    ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
                    if (BYPASS != 0 && wt_ok && bus.wt_addr == ra) begin
                        rd_data_d[k*DATA_W +: DATA_W] = bus.wt_data;
                        rd_busy_d[k] = bs_ok && (bus.busy_addr == ra);
                    end else if (is_zero(ra)) begin
                        rd_data_d[k*DATA_W +: DATA_W] = '0;
                        rd_busy_d[k] = 1'b0;
                    end else begin
                        rd_data_d[k*DATA_W +: DATA_W] = mem_q[ra];
                        rd_busy_d[k] = busy_q[ra];
                    end
                end
            end
        end
    end

    // Control, scoreboard and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    // Register array; cleared by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_busy   = rd_busy_q;
    assign bus.init_done = run;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: one bypassing instance (a)
// and one non-bypassing instance (b) driven with identical stimulus.
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]  rd_en = '0;
    logic [4:0]  ra0 = '0;
    logic [4:0]  ra1 = '0;
    logic        wt_en = 1'b0;
    logic [4:0]  wt_addr = '0;
    logic [31:0] wt_data = '0;
    logic        busy_set = 1'b0;
    logic [4:0]  busy_addr = '0;

    int n_chk = 0;
    int n_pass = 0;
    int ncyc;

    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

    assign ifa.rd_en = rd_en;
    assign ifa.rd_addr = {ra1, ra0};
    assign ifa.wt_en = wt_en;
    assign ifa.wt_addr = wt_addr;
    assign ifa.wt_data = wt_data;
    assign ifa.busy_set = busy_set;
    assign ifa.busy_addr = busy_addr;

    assign ifb.rd_en = rd_en;
    assign ifb.rd_addr = {ra1, ra0};
    assign ifb.wt_en = wt_en;
    assign ifb.wt_addr = wt_addr;
    assign ifb.wt_data = wt_data;
    assign ifb.busy_set = busy_set;
    assign ifb.busy_addr = busy_addr;

    regfile_multiport #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2),
        .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    regfile_multiport #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2),
        .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0;
        wt_en = 1'b0;
        busy_set = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        ncyc = 0;
        while (!ifa.init_done && ncyc < 100) begin
            step();
            ncyc++;
        end
        check(tag, 32'(ncyc), 32'd32);
        check({tag, "_b"}, 32'(ifb.init_done), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", ifa.rd_data[31:0], 32'h0);
        check("rst_busy", 32'(ifa.rd_busy), 32'h0);
        check("rst_done", 32'(ifa.init_done), 32'h0);
        rst_n = 1'b1;
        wait_init("init_cycles");

        for (int a = 0; a < 32; a++) begin
            rd_en = 2'b11;
            ra0 = 5'(a);
            ra1 = 5'(a);
            step();
            check($sformatf("sweep_p0_r%0d", a), ifa.rd_data[31:0], 32'h0);
            check($sformatf("sweep_p1_r%0d", a), ifa.rd_data[63:32], 32'h0);
        end

        idle();
        wt_en = 1'b1; wt_addr = 5'd5; wt_data = 32'hDEADBEEF;
        step();
        idle();
        rd_en = 2'b11; ra0 = 5'd5; ra1 = 5'd0;
        step();
        check("r5_p0", ifa.rd_data[31:0], 32'hDEADBEEF);
        check("r0_p1", ifa.rd_data[63:32], 32'h0);
        check("r5_p0_b", ifb.rd_data[31:0], 32'hDEADBEEF);

        idle();
        rd_en = 2'b10; ra1 = 5'd7;
        wt_en = 1'b1; wt_addr = 5'd7; wt_data = 32'h12345678;
        step();
        check("byp_r7", ifa.rd_data[63:32], 32'h12345678);
        check("nobyp_r7_old", ifb.rd_data[63:32], 32'h0);
        check("hold_p0", ifa.rd_data[31:0], 32'hDEADBEEF);
        wt_en = 1'b0;
        step();
        check("nobyp_r7_new", ifb.rd_data[63:32], 32'h12345678);

        idle();
        busy_set = 1'b1; busy_addr = 5'd9;
        step();
        idle();
        rd_en = 2'b01; ra0 = 5'd9;
        step();
        check("r9_busy", 32'(ifa.rd_busy[0]), 32'h1);
        wt_en = 1'b1; wt_addr = 5'd9; wt_data = 32'h55;
        step();
        check("r9_byp_data", ifa.rd_data[31:0], 32'h55);
        check("r9_byp_busy", 32'(ifa.rd_busy[0]), 32'h0);
        check("r9_nobyp_busy", 32'(ifb.rd_busy[0]), 32'h1);
        busy_set = 1'b1; busy_addr = 5'd9; wt_data = 32'h66;
        step();
        check("r9_set_win_data", ifa.rd_data[31:0], 32'h66);
        check("r9_set_win_busy", 32'(ifa.rd_busy[0]), 32'h1);
        idle();
        rd_en = 2'b01;
        step();
        check("r9_later_data", ifa.rd_data[31:0], 32'h66);
        check("r9_later_busy", 32'(ifa.rd_busy[0]), 32'h1);
        check("r9_later_busy_b", 32'(ifb.rd_busy[0]), 32'h1);

        idle();
        rd_en = 2'b10; ra1 = 5'd0;
        wt_en = 1'b1; wt_addr = 5'd0; wt_data = 32'hFFFFFFFF;
        busy_set = 1'b1; busy_addr = 5'd0;
        step();
        check("r0_same_data", ifa.rd_data[63:32], 32'h0);
        check("r0_same_busy", 32'(ifa.rd_busy[1]), 32'h0);
        idle();
        rd_en = 2'b10;
        step();
        check("r0_data", ifa.rd_data[63:32], 32'h0);
        check("r0_busy", 32'(ifa.rd_busy[1]), 32'h0);
        check("r0_data_b", ifb.rd_data[63:32], 32'h0);

        idle();
        wt_en = 1'b1; wt_addr = 5'd3; wt_data = 32'hA5A5A5A5;
        busy_set = 1'b1; busy_addr = 5'd3;
        step();
        idle();
        rd_en = 2'b01; ra0 = 5'd3;
        step();
        check("r3_data", ifa.rd_data[31:0], 32'hA5A5A5A5);
        check("r3_busy", 32'(ifa.rd_busy[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", ifa.rd_data[31:0], 32'h0);
        check("mid_rst_busy", 32'(ifa.rd_busy[0]), 32'h0);
        check("mid_rst_done", 32'(ifa.init_done), 32'h0);
        idle();
        step();
        step();
        rst_n = 1'b1;
        wait_init("reinit_cycles");
        rd_en = 2'b01; ra0 = 5'd3;
        step();
        check("r3_post_data", ifa.rd_data[31:0], 32'h0);
        check("r3_post_busy", 32'(ifa.rd_busy[0]), 32'h0);
        check("r3_post_data_b", ifb.rd_data[31:0], 32'h0);
        ra0 = 5'd9;
        step();
        check("r9_post_busy", 32'(ifa.rd_busy[0]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised general-purpose register file for the CPU datapath: NUM_RD synchronous read ports, one write port.
- Adds over the previous-generation register file:
  - configurable width and depth;
  - async reset with a hardware zero-initialisation sweep;
  - optional hardwired-zero register 0;
  - write-to-read bypass;
  - per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (reads, busy checks) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered busy flag of the addressed register
- wt_en  in  1  write enable (RegWrite)
- wt_addr  in  ADDR_W  write address
- wt_data  in  DATA_W  write data
- busy_set  in  1  mark busy_addr as having an outstanding producer
- busy_addr  in  ADDR_W  register to mark busy
- init_done  out  1  high once the init sweep completes

Behaviour:
- Async reset (rst_n low), effective immediately:
  - FSM enters INIT and clears the init counter to 0;
  - rd_data=0, rd_busy=0, init_done=0;
  - all busy bits cleared.
- FSM states: INIT, RUN.
- INIT:
  - each cycle writes 0 to mem[cnt] and increments cnt;
  - after the cycle that writes DEPTH-1, moves to RUN and sets init_done=1 (DEPTH cycles after rst_n deasserts);
  - wt_en and busy_set are ignored;
  - rd_data and rd_busy held at 0.
- RUN:
  - stays in RUN until the next reset;
  - reset mid-operation returns to INIT and re-sweeps.
- Reads:
  - posedge registered, 1-cycle latency;
  - when rd_en[k]=0, port k holds its previous rd_data and rd_busy.
- Bypass, BYPASS=1:
  - condition: wt_en, wt_addr==rd_addr[k], and the address is writable;
  - effect: rd_data[k] takes wt_data in the same edge, and rd_busy[k]=0.
- Bypass, BYPASS=0: same-cycle collision returns the old stored value. The next read returns the new value.
- Writes:
  - mem[wt_addr] <= wt_data on posedge when wt_en, in RUN;
  - the write clears busy[wt_addr].
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - address 0 reads 0;
  - busy_set to address 0 is ignored;
  - rd_busy for address 0 is always 0.
- Scoreboard:
  - busy_set sets busy[busy_addr];
  - if busy_set and a write target the same address in the same cycle, set wins: the bit ends at 1, the data is still written, and the bypassed rd_busy reports 1.
- Multiple read ports may hit the same address; all return identical values.
- Widths: no arithmetic. Addresses are used directly; all DEPTH entries are valid.

Test Plan:
- Reset then idle → init_done low for exactly 32 cycles after rst_n rises, then high; every address read from port 0 and port 1 returns 0x00000000.
- RUN: write 0xDEADBEEF to r5, then the next cycle read r5 on port 0 and r0 on port 1 → one cycle later rd_data0=0xDEADBEEF and rd_data1=0.
- Same-cycle write 0x12345678 to r7 while port 1 reads r7:
  - BYPASS=1 → rd_data1=0x12345678 the next cycle;
  - BYPASS=0 → the old value, then 0x12345678 on the following read.
- busy_set r9 → a read of r9 reports rd_busy=1. Then write r9=0x55 → the same-cycle read gives rd_busy=0 and data 0x55. Then busy_set r9 together with a write to r9 of 0x66 → the bit ends at 1, and a later read shows data 0x66 with rd_busy=1.
- Write r3=0xA5A5A5A5 and mark r3 busy, then assert rst_n low mid-operation → outputs 0 immediately. After release, a re-sweep of 32 cycles completes, and r3 then reads 0 with rd_busy=0.
- Write and busy_set to r0 with ZERO_REG=1 → r0 reads 0 with rd_busy=0.
